pll_rst_seq: RTL and testbench

//  Reset/lock sequencer placed directly downstream of the Gowin rPLL wrapper, in the reference-clock domain.

---
 rtl/pll_rst_pkg.sv | 27 ++
 rtl/lock_sync.sv | 23 ++
 rtl/pll_rst_seq.sv | 144 ++++++++++++++
 tb/tb_pll_rst_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// Shared types and defaults for the PLL reset/lock sequencer.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    StRstPll,
    StWaitLock,
    StStable,
    StRun
  } state_e;

  localparam int unsigned DefSyncStages  = 2;
  localparam int unsigned DefRstCycles   = 16;
  localparam int unsigned DefLockTimeout = 65535;
  localparam int unsigned DefStableCycles = 1024;
  localparam int unsigned DefCntW        = 8;

  // Width of a down-counter able to hold the largest of the three timer loads.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Multi-flop synchroniser for the asynchronous PLL lock signal; clears to 0 on reset.
module lock_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset/lock sequencer in the clkin domain: pulses the PLL reset and holds sys_rst until lock is
// stable. Define PLL_RST_SEQ_STATUS_EN to implement the relock/timeout status counters.
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DefSyncStages,
  parameter int unsigned RST_CYCLES    = DefRstCycles,
  parameter int unsigned LOCK_TIMEOUT  = DefLockTimeout,
  parameter int unsigned STABLE_CYCLES = DefStableCycles,
  parameter int unsigned CNT_W         = DefCntW
) (
  input  logic             clkin_i,
  input  logic             reset_i,
  input  logic             pll_lock_i,
  input  logic             soft_rst_req_i,
  output logic             pll_reset_o,
  output logic             sys_rst_o,
  output logic             ready_o,
  output logic [CNT_W-1:0] relock_cnt_o,
  output logic [CNT_W-1:0] timeout_cnt_o
);

  localparam int unsigned TimerW = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [TimerW-1:0] RstLast    = TimerW'(RST_CYCLES - 1);
  localparam logic [TimerW-1:0] LockLoad   = TimerW'(LOCK_TIMEOUT);
  localparam logic [TimerW-1:0] StableLoad = TimerW'(STABLE_CYCLES);
  localparam logic [TimerW-1:0] TimerOne   = TimerW'(1);

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              pll_reset_q, sys_rst_q, ready_q;
  logic              lock_s;

  lock_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i (clkin_i),
    .rst_i (reset_i),
    .d_i   (pll_lock_i),
    .q_o   (lock_s)
  );

  // RST_PLL counts up from 0 so the timer's reset value already yields a full-length pulse.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (soft_rst_req_i) begin
      state_d = StRstPll;
      timer_d = '0;
    end else begin
      unique case (state_q)
        StRstPll: begin
          if (timer_q == RstLast) begin
            state_d = StWaitLock;
            timer_d = LockLoad;
          end else begin
            timer_d = timer_q + TimerOne;
          end
        end
        StWaitLock: begin
          if (lock_s) begin
            state_d = StStable;
            timer_d = StableLoad;
          end else if (timer_q <= TimerOne) begin
            state_d = StRstPll;
            timer_d = '0;
          end else begin
            timer_d = timer_q - TimerOne;
          end
        end
        StStable: begin
          if (!lock_s) begin
            state_d = StWaitLock;
            timer_d = LockLoad;
          end else if (timer_q <= TimerOne) begin
            state_d = StRun;
            timer_d = '0;
          end else begin
            timer_d = timer_q - TimerOne;
          end
        end
        StRun: begin
          if (!lock_s) begin
            state_d = StRstPll;
            timer_d = '0;
          end
        end
        default: begin
          state_d = StRstPll;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clkin_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StRstPll;
      timer_q     <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pll_reset_q <= (state_d == StRstPll);
      sys_rst_q   <= (state_d != StRun);
      ready_q     <= (state_d == StRun);
    end
  end

  assign pll_reset_o = pll_reset_q;
  assign sys_rst_o   = sys_rst_q;
  assign ready_o     = ready_q;

`ifdef PLL_RST_SEQ_STATUS_EN
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] relock_cnt_q, timeout_cnt_q;
  logic             relock_hit, timeout_hit;

  // A soft request wins over lock loss, so it never counts as a relock or timeout.
  assign relock_hit  = !soft_rst_req_i && (state_q == StRun) && (state_d == StRstPll);
  assign timeout_hit = !soft_rst_req_i && (state_q == StWaitLock) && (state_d == StRstPll);

  always_ff @(posedge clkin_i or posedge reset_i) begin
    if (reset_i) begin
      relock_cnt_q  <= '0;
      timeout_cnt_q <= '0;
    end else begin
      if (relock_hit && (relock_cnt_q != CntMax)) relock_cnt_q <= relock_cnt_q + CntOne;
      if (timeout_hit && (timeout_cnt_q != CntMax)) timeout_cnt_q <= timeout_cnt_q + CntOne;
    end
  end

  assign relock_cnt_o  = relock_cnt_q;
  assign timeout_cnt_o = timeout_cnt_q;
`else
  assign relock_cnt_o  = '0;
  assign timeout_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq: directed scenarios plus random lock/soft-request traffic
// checked every cycle against a phase/elapsed-time reference model.
module tb_pll_rst_seq;

  localparam int unsigned SyncN   = 2;
  localparam int unsigned RstN    = 4;
  localparam int unsigned LockTo  = 20;
  localparam int unsigned StableN = 8;
  localparam int unsigned CntW    = 8;
  localparam int          CntSat  = 255;

  localparam int MRst = 0, MWait = 1, MStable = 2, MRun = 3;

  logic            clkin, reset, pll_lock, soft_rst_req;
  logic            pll_reset, sys_rst, ready;
  logic [CntW-1:0] relock_cnt, timeout_cnt;
  logic            clk_en;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state.
  int ph, rst_done, wait_done, stable_run, relocks, timeouts;
  bit hist[$];

  pll_rst_seq #(
    .SYNC_STAGES   (SyncN),
    .RST_CYCLES    (RstN),
    .LOCK_TIMEOUT  (LockTo),
    .STABLE_CYCLES (StableN),
    .CNT_W         (CntW)
  ) dut (
    .clkin_i        (clkin),
    .reset_i        (reset),
    .pll_lock_i     (pll_lock),
    .soft_rst_req_i (soft_rst_req),
    .pll_reset_o    (pll_reset),
    .sys_rst_o      (sys_rst),
    .ready_o        (ready),
    .relock_cnt_o   (relock_cnt),
    .timeout_cnt_o  (timeout_cnt)
  );

  initial clkin = 1'b0;
  always begin
    #5;
    if (clk_en) clkin = ~clkin;
  end

  function automatic int exp_cnt(input int c);
`ifdef PLL_RST_SEQ_STATUS_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = MRst; rst_done = 0; wait_done = 0; stable_run = 0; relocks = 0; timeouts = 0;
    hist = {};
    for (int i = 0; i < int'(SyncN); i++) hist.push_front(1'b0);
  endtask

  // One clkin edge: lock seen by the sequencer is pll_lock from SyncN edges earlier.
  task automatic model_edge();
    bit ls;
    hist.push_front(pll_lock);
    ls = hist[SyncN];
    void'(hist.pop_back());
    if (soft_rst_req) begin
      ph = MRst; rst_done = 0;
    end else begin
      case (ph)
        MRst: begin
          rst_done++;
          if (rst_done == int'(RstN)) begin ph = MWait; wait_done = 0; end
        end
        MWait: begin
          if (ls) begin
            ph = MStable; stable_run = 0;
          end else begin
            wait_done++;
            if (wait_done == int'(LockTo)) begin
              ph = MRst; rst_done = 0;
              if (timeouts < CntSat) timeouts++;
            end
          end
        end
        MStable: begin
          if (!ls) begin
            ph = MWait; wait_done = 0;
          end else begin
            stable_run++;
            if (stable_run == int'(StableN)) ph = MRun;
          end
        end
        default: begin
          if (!ls) begin
            ph = MRst; rst_done = 0;
            if (relocks < CntSat) relocks++;
          end
        end
      endcase
    end
  endtask

  task automatic check_model();
    check("m_pll_reset", 32'(pll_reset), 32'(ph == MRst));
    check("m_sys_rst", 32'(sys_rst), 32'(ph != MRun));
    check("m_ready", 32'(ready), 32'(ph == MRun));
    check("m_relock_cnt", 32'(relock_cnt), exp_cnt(relocks));
    check("m_timeout_cnt", 32'(timeout_cnt), exp_cnt(timeouts));
  endtask

  task automatic tick();
    @(posedge clkin);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pll_reset"}, 32'(pll_reset), 32'd1);
    check({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_relock_cnt"}, 32'(relock_cnt), 32'd0);
    check({tag, "_timeout_cnt"}, 32'(timeout_cnt), 32'd0);
  endtask

  // Cycles pll_reset stays high from now.
  task automatic pulse_width(output int n);
    n = 0;
    while (pll_reset && n < 60) begin tick(); n++; end
  endtask

  // Raise pll_lock; the rise is taken at the first edge that samples it high.
  task automatic release_latency(output int n);
    pll_lock = 1'b1;
    tick();
    n = 0;
    while (sys_rst && n < 60) begin tick(); n++; end
  endtask

  initial begin
    int n, m, pulses;
    bit prev;
    clk_en = 1'b0; reset = 1'b0; pll_lock = 1'b0; soft_rst_req = 1'b0;
    model_reset();
    #2 reset = 1'b1;
    #2 check_reset_outputs("por");
    #10 reset = 1'b0;
    #2 clk_en = 1'b1;

    // 1: power-up pulse, lock 5 cycles after pll_reset falls.
    pulse_width(n);
    check("t1_pll_reset_width", 32'(n), 32'd4);
    repeat (5) tick();
    release_latency(n);
    check("t1_release_latency", 32'(n), 32'd10);
    check("t1_ready", 32'(ready), 32'd1);

    // 4: lock loss in RUN.
    pll_lock = 1'b0;
    n = 0;
    while (!sys_rst && n < 10) begin tick(); n++; end
    check("t4_sys_rst_delay", 32'(n), 32'd3);
    pulse_width(n);
    check("t4_pll_reset_width", 32'(n), 32'd4);
    check("t4_relock_cnt", 32'(relock_cnt), exp_cnt(1));

    // 3: one-cycle lock glitch while stable.
    pll_lock = 1'b1;
    repeat (6) tick();
    pll_lock = 1'b0;
    tick();
    release_latency(n);
    check("t3_release_latency", 32'(n), 32'd10);
    check("t3_ready", 32'(ready), 32'd1);

    // 5: soft request on the same edge the synced lock falls.
    pll_lock = 1'b0;
    tick();
    tick();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    check("t5_pll_reset_now", 32'(pll_reset), 32'd1);
    pulse_width(n);
    check("t5_pll_reset_width", 32'(n), 32'd4);
    pll_lock = 1'b1;
    pulses = 0;
    prev = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (pll_reset && !prev) pulses++;
      prev = pll_reset;
    end
    check("t5_extra_pulses", 32'(pulses), 32'd0);
    check("t5_relock_cnt", 32'(relock_cnt), exp_cnt(1));
    check("t5_ready", 32'(ready), 32'd1);

    // 2: lock never returns -> periodic re-init with timeouts.
    pll_lock = 1'b0;
    n = 0;
    while (!pll_reset && n < 10) begin tick(); n++; end
    pulse_width(n);
    for (int k = 1; k <= 3; k++) begin
      n = 0;
      while (!pll_reset && n < 60) begin tick(); n++; end
      check("t2_wait_cycles", 32'(n), 32'd20);
      check("t2_timeout_cnt", 32'(timeout_cnt), exp_cnt(k));
      pulse_width(m);
      check("t2_pll_reset_width", 32'(m), 32'd4);
    end
    check("t2_relock_cnt", 32'(relock_cnt), exp_cnt(2));

    // Random lock behaviour and soft requests.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) pll_lock = ~pll_lock;
      soft_rst_req = ($urandom_range(63) == 0);
      tick();
    end
    soft_rst_req = 1'b0;

    // 6: async reset mid-WAIT_LOCK with the clock stopped.
    pll_lock = 1'b0;
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    repeat (8) tick();
    check("t6_pre_pll_reset", 32'(pll_reset), 32'd0);
    clk_en = 1'b0;
    #20 reset = 1'b1;
    model_reset();
    #1 check_reset_outputs("t6_async");
    #20 reset = 1'b0;
    #3 check_reset_outputs("t6_released");
    clk_en = 1'b1;
    pulse_width(n);
    check("t6_pll_reset_width", 32'(n), 32'd4);
    repeat (5) tick();
    release_latency(n);
    check("t6_release_latency", 32'(n), 32'd10);
    check("t6_ready", 32'(ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
